meas_ctrl: RTL and testbench

MEAS_CTRL -- requirements
Module: meas_ctrl

---
 rtl/meas_pkg.sv | 14 +
 rtl/edge_cnt.sv | 42 ++++
 rtl/meas_ctrl.sv | 118 +++++++++++
 tb/tb_meas_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/meas_pkg.sv
// Shared types and defaults for the frequency measurement controller.
package meas_pkg;

    localparam int unsigned FRE_W           = 16;
    localparam int unsigned GATE_CYCLES_DEF = 50_000_000;
    localparam int unsigned ALARM_TH_DEF    = 20000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/edge_cnt.sv
// Saturating edge counter with synchronous clear; exposes its next value so
// the final gate cycle's pulse can be latched on the same edge.
module edge_cnt
    import meas_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [FRE_W-1:0] o_cnt_nxt_c,
    output logic             o_ovf_nxt_c
);

    localparam logic [FRE_W-1:0] CNT_MAX = '1;

    logic [FRE_W-1:0] r_cnt;
    logic             r_ovf;

    // Overflow is flagged the moment the counter reaches its ceiling.
    always_comb begin
        o_cnt_nxt_c = r_cnt;
        o_ovf_nxt_c = r_ovf;
        if (i_clr) begin
            o_cnt_nxt_c = '0;
            o_ovf_nxt_c = 1'b0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            o_cnt_nxt_c = r_cnt + FRE_W'(1);
            o_ovf_nxt_c = (r_cnt == (CNT_MAX - FRE_W'(1)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= o_cnt_nxt_c;
            r_ovf <= o_ovf_nxt_c;
        end
    end

endmodule

// File: rtl/meas_ctrl.sv
// Gate-window frequency meter: counts sig_pulse over GATE_CYCLES clocks and
// latches the count, overflow and threshold alarm at the end of each window.
module meas_ctrl
    import meas_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int unsigned ALARM_TH    = ALARM_TH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             sig_pulse,
    output logic             busy,
    output logic [FRE_W-1:0] fre,
    output logic             fre_valid,
    output logic             ovf,
    output logic             over_th
);

    localparam int unsigned TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_nxt;
    logic             w_gate_start;
    logic             w_cnt_en;
    logic [FRE_W-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;

    logic             r_busy;
    logic [FRE_W-1:0] r_fre;
    logic             r_fre_valid;
    logic             r_ovf;
    logic             r_over_th;

    assign w_cnt_en = (r_state == GATE) && sig_pulse;

    edge_cnt u_edge_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_gate_start),
        .i_en        (w_cnt_en),
        .o_cnt_nxt_c (w_cnt_nxt),
        .o_ovf_nxt_c (w_ovf_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    // Next state and gate timer; a window (re)start clears timer and counter.
    always_comb begin
        w_state_nxt  = r_state;
        w_tmr_nxt    = r_tmr;
        w_gate_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (start || cont) begin
                    w_state_nxt  = GATE;
                    w_tmr_nxt    = '0;
                    w_gate_start = 1'b1;
                end
            end
            GATE: begin
                if (r_tmr == TMR_LAST) begin
                    w_state_nxt = LATCH;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end
            end
            LATCH: begin
                if (cont) begin
                    w_state_nxt  = GATE;
                    w_tmr_nxt    = '0;
                    w_gate_start = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Result registers load on the edge that enters LATCH and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_fre       <= '0;
            r_fre_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_over_th   <= 1'b0;
        end else begin
            r_busy      <= (w_state_nxt != IDLE);
            r_fre_valid <= (w_state_nxt == LATCH);
            if ((r_state == GATE) && (w_state_nxt == LATCH)) begin
                r_fre     <= w_cnt_nxt;
                r_ovf     <= w_ovf_nxt;
                r_over_th <= (32'(w_cnt_nxt) > ALARM_TH);
            end
        end
    end

    assign busy      = r_busy;
    assign fre       = r_fre;
    assign fre_valid = r_fre_valid;
    assign ovf       = r_ovf;
    assign over_th   = r_over_th;

endmodule

// File: tb/tb_meas_ctrl.sv
// Scoreboard bench for meas_ctrl: short-gate instance for window behaviour,
// long-gate instance for counter saturation.
module tb_meas_ctrl;

    localparam int unsigned GC   = 100;
    localparam int unsigned TH   = 20;
    localparam int unsigned GC_S = 70000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, cont, sig_pulse;
    logic        busy, fre_valid, ovf, over_th;
    logic [15:0] fre;

    logic        s_start, s_sig;
    logic        s_busy, s_valid, s_ovf, s_over;
    logic [15:0] s_fre;

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_valid = 0;
    int          n_exp   = 0;
    logic [17:0] sb_q[$];
    logic [17:0] e_mon;

    always #5 clk = ~clk;

    meas_ctrl #(.GATE_CYCLES(GC), .ALARM_TH(TH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cont      (cont),
        .sig_pulse (sig_pulse),
        .busy      (busy),
        .fre       (fre),
        .fre_valid (fre_valid),
        .ovf       (ovf),
        .over_th   (over_th)
    );

    meas_ctrl #(.GATE_CYCLES(GC_S), .ALARM_TH(TH)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s_start),
        .cont      (1'b0),
        .sig_pulse (s_sig),
        .busy      (s_busy),
        .fre       (s_fre),
        .fre_valid (s_valid),
        .ovf       (s_ovf),
        .over_th   (s_over)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Expected {ovf, over_th, fre} for a window that saw n pulses.
    function automatic logic [17:0] exp_of(input int n);
        logic [15:0] f;
        logic        sat;
        sat = (n >= 65535);
        f   = sat ? 16'hFFFF : 16'(n);
        return {sat, (32'(f) > TH), f};
    endfunction

    always @(negedge clk) begin
        if (fre_valid) begin
            n_valid++;
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e_mon = sb_q.pop_front();
                chk("fre", 32'(fre), 32'(e_mon[15:0]));
                chk("ovf", 32'(ovf), 32'(e_mon[17]));
                chk("over_th", 32'(over_th), 32'(e_mon[16]));
            end
        end
    end

    // One start-triggered window; pulses at the head or tail of the gate.
    task automatic gate_run(input int np, input bit tail, input int restart_at, input string tag);
        int lat;
        lat = -1;
        sb_q.push_back(exp_of(np));
        n_exp++;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 2; k <= int'(GC) + 4; k++) begin
            int idx;
            idx = k - 2;
            @(negedge clk);
            start     = (idx == restart_at);
            sig_pulse = (idx < int'(GC)) && (tail ? (idx >= int'(GC) - np) : (idx < np));
            if (idx == int'(GC) / 2) chk({tag, "_busy"}, 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            if (fre_valid && lat < 0) lat = k;
        end
        sig_pulse = 1'b0;
        start     = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'(GC + 1));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int np_c[3];
        bit found;
        np_c = '{5, 30, 5};
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; sig_pulse = 1'b0;
        s_start = 1'b0; s_sig = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fre", 32'(fre), 32'd0);
        chk("rst_valid", 32'(fre_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_over", 32'(over_th), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_rst", 32'(busy), 32'd0);

        gate_run(10, 1'b0, -1, "single");
        gate_run(20, 1'b1, -1, "th20");
        gate_run(21, 1'b0, -1, "th21");

        // Reset in the middle of a window discards it.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int idx = 0; idx < 50; idx++) begin
            @(negedge clk);
            start     = 1'b0;
            sig_pulse = (idx < 7);
            @(posedge clk);
        end
        @(negedge clk);
        sig_pulse = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fre", 32'(fre), 32'd0);
        chk("mid_rst_valid", 32'(fre_valid), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_over", 32'(over_th), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        gate_run(15, 1'b0, -1, "post_rst");

        // Continuous mode: three windows, a pulse in every LATCH cycle.
        for (int w = 0; w < 3; w++) begin
            sb_q.push_back(exp_of(np_c[w]));
            n_exp++;
        end
        @(negedge clk);
        cont = 1'b1;
        @(posedge clk);
        for (int t = 0; t < 3 * (int'(GC) + 1) + 3; t++) begin
            int pos;
            int w;
            pos = t % (int'(GC) + 1);
            w   = t / (int'(GC) + 1);
            @(negedge clk);
            if (w < 3) sig_pulse = (pos == int'(GC)) ? 1'b1 : (pos < np_c[w]);
            else       sig_pulse = 1'b0;
            if (w == 2 && pos == 10) cont = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        sig_pulse = 1'b0;
        chk("cont_idle", 32'(busy), 32'd0);

        gate_run(8, 1'b0, 30, "restart");
        repeat (150) @(negedge clk);

        // Saturation on the long-gate instance.
        @(negedge clk);
        s_sig   = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < int'(GC_S) + 10; i++) begin
            @(posedge clk);
            #1;
            if (s_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("sat_seen", 32'(found), 32'd1);
        chk("sat_fre", 32'(s_fre), 32'hFFFF);
        chk("sat_ovf", 32'(s_ovf), 32'd1);
        chk("sat_over", 32'(s_over), 32'd1);
        s_sig = 1'b0;

        @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("valid_count", 32'(n_valid), 32'(n_exp));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
